frontport_wb_bridge: RTL and testbench
======================================

// Module: frontport_wb_bridge
// PURPOSE
//  Byte-stream-to-Wishbone debug master; drives the SoC FrontPort (arbiter master 2).
//  Receives command packets from a byte source (UART RX path), runs one 32-bit Wishbone
//  single-beat transfer, and returns a status/data response on a byte sink (UART TX path).
//  Lets a host peek/poke RAM and peripherals and load code while the core runs or is held.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles to wait for wb_ack_i before aborting; legal range 1..65535
// PORTS
//  wb_clk_i      in   1   clock
//  wb_rst_i      in   1   reset, asynchronous, active-high
//  rx_data_i     in   8   command byte in
//  rx_valid_i    in   1   rx_data_i valid
//  rx_ready_o    out  1   bridge accepts byte (transfer = rx_valid_i & rx_ready_o)
//  tx_data_o     out  8   response byte out
//  tx_valid_o    out  1   tx_data_o valid; held with tx_data_o stable until tx_ready_i
//  tx_ready_i    in   1   sink accepts byte
//  wb_adr_o      out  32  byte address
//  wb_dat_o      out  32  write data
//  wb_dat_i      in   32  read data
//  wb_we_o       out  1   write enable
//  wb_sel_o      out  4   byte select, constant 4'b1111
//  wb_stb_o      out  1   strobe
//  wb_cyc_o      out  1   cycle
//  wb_ack_i      in   1   acknowledge
//  busy_o        out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rx_ready_o=1, tx_valid_o=0, tx_data_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0,
//   wb_adr_o=wb_dat_o=0, busy_o=0. Async assert aborts any transfer and drops cyc/stb at once.
//  Packets, multi-byte fields little-endian:
//   0x01 RD: A0..A3 -> resp 0x00,D0..D3      0x02 WR: A0..A3,D0..D3 -> resp 0x00
//   timeout -> resp single 0xEE; unknown cmd -> resp single 0xFF, no bus access.
//  FSM: IDLE -> ADDR (4 bytes) -> [WR: DATA (4 bytes)] -> BUS -> RESP -> IDLE.
//   2-bit byte counter per field, wraps 3->0 on field completion.
//   rx_ready_o=1 only in IDLE/ADDR/DATA; 0 in BUS/RESP (no input bytes dropped or buffered).
//  BUS: cyc=stb=1 asserted the cycle after the last field byte is accepted; wb_adr_o[1:0]
//   forced to 2'b00. On ack: deassert cyc/stb same edge, latch wb_dat_i (RD), go RESP.
//   Ack sampled only while cyc&stb. Timeout counter cleared on BUS entry; when it reaches
//   TIMEOUT_CYCLES without ack -> drop cyc/stb, RESP with 0xEE; a late ack is ignored.
//   Ack on the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
//  RESP: 5-byte (RD ok) or 1-byte response via shift register; tx_valid_o rises the cycle
//   after BUS exit; next byte presented the cycle after each tx_valid_o&tx_ready_i.
//   After last byte accepted -> IDLE, rx_ready_o=1 next cycle.
//  Unknown cmd: IDLE -> RESP directly (0xFF); bytes after it are parsed as new commands.
//  wb_adr_o/wb_dat_o hold their last values between transfers.
// CONFIGURATION
//  FP_AUTOINC_EN defined: extra cmds 0x81 (RD) / 0x82 (WR) carry no address bytes and use
//   last completed address + 4 (32-bit wrap 0xFFFFFFFC -> 0x00000000); 0x82 still takes
//   4 data bytes. Address advances only on successful ack, not on timeout. Last address
//   resets to 0.
//  FP_AUTOINC_EN undefined: 0x81/0x82 are unknown commands -> 0xFF response.
// TESTING
//  WR 02 00 00 01 00 EF BE AD DE, ack 1 cycle later -> adr=0x00010000, dat=0xDEADBEEF,
//   we=1, sel=F, one cyc/stb pulse; tx 0x00.
//  RD 01 00 00 01 00, slave returns 0xDEADBEEF -> tx 00 EF BE AD DE, we=0.
//  RD to unmapped addr, no ack, TIMEOUT_CYCLES=16 -> cyc/stb high exactly 16 cycles,
//   tx 0xEE; ack forced on cycle 17 has no effect.
//  Cmd 0x55 then RD 01 04 00 00 00 -> tx 0xFF, then read of 0x00000004 served normally.
//  tx_ready_i held low 10 cycles during read response -> tx_data_o stable, rx_ready_o=0,
//   no byte lost; wb_rst_i mid-BUS -> cyc/stb low asynchronously, IDLE, no response.
//  FP_AUTOINC_EN: WR to 0xFFFFFFFC then 82 + 4 data bytes -> second write hits 0x00000000;
//   without macro, 0x81 -> tx 0xFF.

Source files
------------

// File: rtl/frontport_wb_bridge.sv
// Byte-stream command packets -> single-beat 32-bit Wishbone master, with a byte-stream response.
// Optional auto-increment commands 0x81/0x82 are built in when FP_AUTOINC_EN is defined.
module frontport_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [23:0] fld_sh;
  logic [31:0] adr_r, dat_r;
  logic        we_r;
  logic [15:0] to_cnt;
  logic [39:0] tx_sh;
  logic [2:0]  tx_left;
  logic        rx_fire, tx_fire, fld_last, timed_out;
  logic        cmd_rd, cmd_wr, cmd_inc;
`ifdef FP_AUTOINC_EN
  logic [31:0] last_adr;
`endif

  assign rx_fire   = rx_valid_i & rx_ready_o;
  assign tx_fire   = tx_valid_o & tx_ready_i;
  assign fld_last  = (byte_cnt == 2'd3);
  assign timed_out = (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  assign wb_adr_o  = adr_r;
  assign wb_dat_o  = dat_r;
  assign wb_we_o   = we_r;
  assign wb_sel_o  = 4'b1111;
  assign tx_data_o = tx_sh[7:0];

  always_comb begin
    cmd_rd  = 1'b0;
    cmd_wr  = 1'b0;
    cmd_inc = 1'b0;
    case (rx_data_i)
      8'h01: cmd_rd = 1'b1;
      8'h02: cmd_wr = 1'b1;
`ifdef FP_AUTOINC_EN
      8'h81: begin cmd_rd = 1'b1; cmd_inc = 1'b1; end
      8'h82: begin cmd_wr = 1'b1; cmd_inc = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (rx_fire) begin
        if (cmd_inc)              state_nxt = cmd_wr ? S_DATA : S_BUS;
        else if (cmd_rd | cmd_wr) state_nxt = S_ADDR;
        else                      state_nxt = S_RESP;
      end
      S_ADDR: if (rx_fire && fld_last) state_nxt = we_r ? S_DATA : S_BUS;
      S_DATA: if (rx_fire && fld_last) state_nxt = S_BUS;
      S_BUS:  if (wb_ack_i || timed_out) state_nxt = S_RESP;
      S_RESP: if (tx_fire && tx_left == 3'd1) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus and handshake strobes decode straight from the state register, so reset drops them at once.
  always_comb begin
    rx_ready_o = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
    wb_cyc_o   = (state == S_BUS);
    wb_stb_o   = (state == S_BUS);
    tx_valid_o = (state == S_RESP);
    busy_o     = (state != S_IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      byte_cnt <= '0;
      fld_sh   <= '0;
      adr_r    <= '0;
      dat_r    <= '0;
      we_r     <= 1'b0;
      to_cnt   <= '0;
      tx_sh    <= '0;
      tx_left  <= '0;
`ifdef FP_AUTOINC_EN
      last_adr <= '0;
`endif
    end else begin
      if (rx_fire) fld_sh <= {rx_data_i, fld_sh[23:8]};
      if (rx_fire && (state == S_ADDR || state == S_DATA)) byte_cnt <= byte_cnt + 2'd1;
      to_cnt <= (state == S_BUS) ? to_cnt + 16'd1 : 16'd0;

      case (state)
        S_IDLE: if (rx_fire) begin
          if (cmd_rd | cmd_wr) we_r <= cmd_wr;
          else begin
            tx_sh   <= 40'hFF;
            tx_left <= 3'd1;
          end
`ifdef FP_AUTOINC_EN
          if (cmd_inc) adr_r <= last_adr + 32'd4;
`endif
        end
        S_ADDR: if (rx_fire && fld_last) adr_r <= {rx_data_i, fld_sh[23:2], 2'b00};
        S_DATA: if (rx_fire && fld_last) dat_r <= {rx_data_i, fld_sh};
        S_BUS: begin
          // Ack wins over a timeout that lands on the same cycle.
          if (wb_ack_i) begin
            tx_sh   <= we_r ? 40'h0 : {wb_dat_i, 8'h00};
            tx_left <= we_r ? 3'd1 : 3'd5;
`ifdef FP_AUTOINC_EN
            last_adr <= adr_r;
`endif
          end else if (timed_out) begin
            tx_sh   <= 40'hEE;
            tx_left <= 3'd1;
          end
        end
        S_RESP: if (tx_fire) begin
          tx_sh   <= {8'h00, tx_sh[39:8]};
          tx_left <= tx_left - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frontport_wb_bridge.sv
// Randomized packet bench for frontport_wb_bridge against a packet-level memory model.
module tb_frontport_wb_bridge;
  localparam int TO = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready = 1'b0;
  logic [31:0] adr, dat_o, dat_i = '0;
  logic        we, stb, cyc, ack = 1'b0, busy;
  logic [3:0]  sel;

  frontport_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_we_o(we), .wb_sel_o(sel),
    .wb_stb_o(stb), .wb_cyc_o(cyc), .wb_ack_i(ack), .busy_o(busy));

  always #5 clk = ~clk;

  int vec_cnt = 0, err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference memory: written only by the model; unwritten words read a hash of the address.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_last = '0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Wishbone slave + bus monitor
  bit          slave_mute = 0;
  int          slave_dly = 0, wait_cnt = 0, cur_len = 0, last_len = 0, pulses = 0, obs_n = 0;
  logic [31:0] obs_adr, obs_dat;
  logic        obs_we;
  logic [3:0]  obs_sel;

  initial begin
    forever begin
      @(posedge clk); #1;
      ack = 1'b0;
      if (cyc && stb) begin
        cur_len++;
        if (!slave_mute && wait_cnt == slave_dly) begin
          ack = 1'b1; dat_i = memval(adr);
          obs_adr = adr; obs_we = we; obs_dat = dat_o; obs_sel = sel; obs_n++;
        end
        wait_cnt++;
      end else begin
        if (cur_len != 0) begin
          last_len = cur_len; pulses++;
          if (slave_mute) ack = 1'b1;  // late ack after the bridge gave up
        end
        cur_len = 0; wait_cnt = 0;
      end
    end
  end

  task automatic send(input logic [7:0] pkt[$]);
    foreach (pkt[i]) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      rx_data = pkt[i]; rx_valid = 1'b1;
      for (int n = 0; !rx_ready; n++) begin
        if (n > 100) begin
          chk("rx_ready_wait", 0, 1); rx_valid = 1'b0; return;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic recv(input int n, input int stall, output logic [7:0] got[$]);
    logic [7:0] d;
    got = {};
    for (int i = 0; i < n; i++) begin
      for (int w = 0; !tx_valid; w++) begin
        if (w > TO + 60) begin chk("tx_valid_wait", 0, 1); return; end
        @(posedge clk); #1;
      end
      d = tx_data;
      repeat (stall < 0 ? $urandom_range(0, 3) : stall) begin
        @(posedge clk); #1;
        chk("tx_stable", tx_data, d);
        chk("tx_hold_valid", tx_valid, 1);
        chk("rx_blocked", rx_ready, 0);
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      got.push_back(d);
    end
  endtask

  task automatic do_cmd(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                        input bit mute, input int dly, input int stall);
    logic [7:0]  pkt[$], exp[$], got[$];
    logic [31:0] ea, v;
    bit known = 0, rd = 0, hasadr = 0;
    int p0, o0;
    ea = a & 32'hFFFF_FFFC;
    case (cmd)
      8'h01: begin known = 1; rd = 1; hasadr = 1; end
      8'h02: begin known = 1; hasadr = 1; end
`ifdef FP_AUTOINC_EN
      8'h81: begin known = 1; rd = 1; ea = m_last + 32'd4; end
      8'h82: begin known = 1; ea = m_last + 32'd4; end
`endif
      default: ;
    endcase
    pkt.push_back(cmd);
    if (hasadr) for (int i = 0; i < 4; i++) pkt.push_back(a[8*i +: 8]);
    if (known && !rd) for (int i = 0; i < 4; i++) pkt.push_back(d[8*i +: 8]);
    if (!known) exp.push_back(8'hFF);
    else if (mute) exp.push_back(8'hEE);
    else begin
      exp.push_back(8'h00);
      if (rd) begin
        v = memval(ea);
        for (int i = 0; i < 4; i++) exp.push_back(v[8*i +: 8]);
      end
    end
    slave_mute = mute; slave_dly = dly;
    p0 = pulses; o0 = obs_n;
    send(pkt);
    recv(exp.size(), stall, got);
    foreach (exp[i]) chk($sformatf("rsp[%0d] cmd %0h", i, cmd), (i < got.size()) ? got[i] : 'x, exp[i]);
    chk("rx_ready_after", rx_ready, 1);
    chk("busy_after", busy, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("no_extra_tx", tx_valid, 0);
    chk("cyc_pulses", pulses - p0, known ? 1 : 0);
    if (known) begin
      chk("txn_count", obs_n - o0, mute ? 0 : 1);
      chk("cyc_len", last_len, mute ? TO : dly + 1);
      if (!mute) begin
        chk("wb_adr", obs_adr, ea);
        chk("wb_we", obs_we, !rd);
        chk("wb_sel", obs_sel, 4'hF);
        if (!rd) chk("wb_dat", obs_dat, d);
        if (!rd) mem[ea] = d;
        m_last = ea;
      end
    end
    slave_mute = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd;
    int r, dly;
    bit seen_tx;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_cmd(8'h02, 32'h0001_0000, 32'hDEADBEEF, 0, 0, -1);
    do_cmd(8'h01, 32'h0001_0000, 0, 0, 1, -1);
    do_cmd(8'h01, 32'h8000_0000, 0, 1, 0, -1);         // timeout + late ack
    do_cmd(8'h01, 32'h0000_0040, 0, 0, TO - 1, -1);    // ack on the final allowed cycle
    do_cmd(8'h55, 0, 0, 0, 0, -1);
    do_cmd(8'h01, 32'h0000_0004, 0, 0, 0, -1);
    do_cmd(8'h01, 32'h0001_0000, 0, 0, 2, 10);         // sink stalls mid-response
`ifdef FP_AUTOINC_EN
    do_cmd(8'h02, 32'hFFFF_FFFC, 32'h1234_5678, 0, 0, -1);
    do_cmd(8'h82, 0, 32'hCAFE_F00D, 0, 0, -1);
    do_cmd(8'h81, 0, 0, 0, 0, -1);
`else
    do_cmd(8'h81, 0, 0, 0, 0, -1);
    do_cmd(8'h82, 0, 0, 0, 0, -1);
`endif

    // Reset in the middle of a bus cycle
    slave_mute = 1;
    send('{8'h01, 8'h10, 8'h00, 8'h00, 8'h00});
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc", cyc, 0);
    chk("mid_rst_stb", stb, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_ready", rx_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    slave_mute = 0;
    m_last = '0;
    seen_tx = 0;
    repeat (20) begin @(posedge clk); #1; if (tx_valid) seen_tx = 1; end
    chk("mid_rst_no_resp", seen_tx, 0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: cmd = 8'h01;
        4, 5, 6:    cmd = 8'h02;
        7:          cmd = 8'h81;
        8:          cmd = 8'h82;
        default:    cmd = 8'($urandom);
      endcase
      dly = $urandom_range(0, 7);
      if (dly == 7) dly = TO - 1;
      do_cmd(cmd, (k % 3 == 0) ? 32'h0000_0100 + 32'($urandom_range(0, 15)) : $urandom,
             $urandom, $urandom_range(0, 7) == 0, dly, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
